// File: rtl/dphy_pkg.sv
// D-PHY receive shared types and constants.
// Alignment FSM state encoding and the HS sync byte.
package dphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STABLE = 3'd1,
        ST_SRST   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } align_state_e;

    localparam logic [7:0] DPHY_SYNC_WORD = 8'hB8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer.
// Reset value is a parameter so idle-high signals can reuse it.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // metastability stage followed by the output stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/dphy_rx_align_ctrl.sv
// D-PHY RX lane bring-up: clock stability, ISERDES reset,
// then bitslip search for the HS sync byte.
module dphy_rx_align_ctrl
    import dphy_pkg::*;
#(
    parameter int         STABLE_TICKS     = 16,
    parameter int         SERDES_RST_TICKS = 4,
    parameter int         SLIP_GAP         = 3,
    parameter int         MAX_SLIPS        = 8,
    parameter logic [7:0] SYNC_WORD        = DPHY_SYNC_WORD
) (
    input  logic       obs_clk_i,
    input  logic       rst_i,
    input  logic       clk_present_i,
    input  logic       lane_en_i,
    input  logic [7:0] data_i,
    output logic       serdes_rst_o,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       align_err_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = max3(STABLE_TICKS, SERDES_RST_TICKS, SLIP_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] SRST_LAST   = CNT_W'(SERDES_RST_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(SLIP_GAP - 1);
    localparam logic [SLIP_W-1:0] SLIP_MAX   = SLIP_W'(MAX_SLIPS);

    logic              present;
    logic              lane_ok;
    align_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SLIP_W-1:0] slip_q, slip_d;
    logic              serdes_rst_d, bitslip_d, locked_d, align_err_d;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_present_sync (
        .clk_i (obs_clk_i),
        .rst_i (rst_i),
        .d_i   (clk_present_i),
        .q_o   (present)
    );

    assign lane_ok = lane_en_i & present;

    // state, tick counter and slip counter registers
    always_ff @(posedge obs_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slip_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slip_q  <= slip_d;
        end
    end

    // next state; losing the lane overrides every other decision
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (lane_ok) state_d = ST_STABLE;
            ST_STABLE: if (cnt_q == STABLE_LAST) state_d = ST_SRST;
            ST_SRST:   if (cnt_q == SRST_LAST) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == GAP_LAST) state_d = ST_CHECK;
            ST_CHECK: begin
                if (data_i == SYNC_WORD)  state_d = ST_LOCKED;
                else if (slip_q == SLIP_MAX) state_d = ST_FAIL;
                else                      state_d = ST_SETTLE;
            end
            ST_LOCKED: state_d = ST_LOCKED;
            ST_FAIL:   state_d = ST_FAIL;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !lane_ok) state_d = ST_IDLE;
    end

    // counters clear on any state entry; slips saturate at MAX_SLIPS
    always_comb begin
        cnt_d  = cnt_q;
        slip_d = slip_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {ST_STABLE, ST_SRST, ST_SETTLE}) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_SRST && state_d == ST_SETTLE) begin
            slip_d = '0;
        end else if (state_q == ST_CHECK && state_d == ST_SETTLE
                     && slip_q < SLIP_MAX) begin
            slip_d = slip_q + 1'b1;
        end
    end

    // output values for the state being entered
    always_comb begin
        serdes_rst_d = state_d inside {ST_IDLE, ST_STABLE, ST_SRST};
        bitslip_d    = (state_q == ST_CHECK) && (state_d == ST_SETTLE);
        locked_d     = (state_d == ST_LOCKED);
        align_err_d  = (state_d == ST_FAIL);
    end

    // registered outputs
    always_ff @(posedge obs_clk_i or posedge rst_i) begin
        if (rst_i) begin
            serdes_rst_o <= 1'b1;
            bitslip_o    <= 1'b0;
            locked_o     <= 1'b0;
            align_err_o  <= 1'b0;
        end else begin
            serdes_rst_o <= serdes_rst_d;
            bitslip_o    <= bitslip_d;
            locked_o     <= locked_d;
            align_err_o  <= align_err_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_dphy_rx_align_ctrl.sv
// Scoreboard bench for dphy_rx_align_ctrl: expected output
// events are predicted from timing arithmetic and checked on change.
module tb_dphy_rx_align_ctrl;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam int         NMAX = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  v;
    } ev_t;

    logic       obs_clk_i = 1'b0;
    logic       rst_i;
    logic       clk_present_i;
    logic       lane_en_i;
    logic [7:0] data_i;
    logic       serdes_rst_o;
    logic       bitslip_o;
    logic       locked_o;
    logic       align_err_o;
    logic [2:0] state_o;

    logic [3:0]  obs;
    logic [3:0]  prev = 4'b1000;
    bit          mon_en = 1'b0;
    int unsigned cyc = 0;
    ev_t         exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          need = 0;
    int          base = 0;
    int          slips_seen = 0;
    bit          scramble = 1'b0;

    dphy_rx_align_ctrl dut (
        .obs_clk_i     (obs_clk_i),
        .rst_i         (rst_i),
        .clk_present_i (clk_present_i),
        .lane_en_i     (lane_en_i),
        .data_i        (data_i),
        .serdes_rst_o  (serdes_rst_o),
        .bitslip_o     (bitslip_o),
        .locked_o      (locked_o),
        .align_err_o   (align_err_o),
        .state_o       (state_o)
    );

    assign obs = {serdes_rst_o, bitslip_o, locked_o, align_err_o};

    always #5 obs_clk_i = ~obs_clk_i;

    always @(posedge obs_clk_i) cyc <= cyc + 1;

    function automatic logic [7:0] rnd_nonsync();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (b == SYNC) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // ISERDES model: presents the sync byte after `need` slips
    always @(negedge obs_clk_i) begin
        if (bitslip_o) slips_seen = slips_seen + 1;
        if (!scramble && (slips_seen - base) >= need) data_i = SYNC;
        else data_i = rnd_nonsync();
    end

    // monitor: every output change must match the next expected event
    always @(negedge obs_clk_i) begin
        if (mon_en && obs !== prev) begin
            ev_t e;
            n_chk = n_chk + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL event: cyc %0d got %b, required no event",
                         cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.v === obs) n_pass = n_pass + 1;
                else $display("FAIL event: cyc %0d got %b, required cyc %0d %b",
                              cyc, obs, e.cyc, e.v);
            end
            prev = obs;
        end
    end

    task automatic push(input int unsigned c, input logic [3:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_chk = n_chk + 1;
        if (got == want) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge obs_clk_i);
    endtask

    task automatic set_need(input int k);
        need = k;
        base = slips_seen;
    endtask

    function automatic int unsigned end_cyc(input int unsigned t, input int k);
        return (k <= NMAX) ? t + 24 + 4 * k : t + 24 + 4 * NMAX;
    endfunction

    // t = cycle the FSM enters STABLE; 16 stable + 4 reset ticks,
    // then 3 settle + 1 check per attempt
    task automatic expect_align(input int unsigned t, input int k);
        int n;
        n = (k <= NMAX) ? k : NMAX;
        push(t + 20, 4'b0000);
        for (int j = 0; j < n; j++) begin
            push(t + 24 + 4 * j, 4'b0100);
            push(t + 25 + 4 * j, 4'b0000);
        end
        if (k <= NMAX) push(t + 24 + 4 * k, 4'b0010);
        else           push(t + 24 + 4 * NMAX, 4'b0001);
    endtask

    task automatic exit_present();
        int unsigned x;
        scramble = 1'b1;
        repeat (10) @(negedge obs_clk_i);
        x = cyc;
        push(x + 3, 4'b1000);
        clk_present_i = 1'b0;
        wait_to(x + 8);
        scramble = 1'b0;
    endtask

    task automatic exit_lane();
        int unsigned x;
        repeat (10) @(negedge obs_clk_i);
        x = cyc;
        push(x + 1, 4'b1000);
        lane_en_i = 1'b0;
        repeat (2) @(negedge obs_clk_i);
        clk_present_i = 1'b0;
        repeat (4) @(negedge obs_clk_i);
        lane_en_i = 1'b1;
    endtask

    task automatic run_align(input int k);
        int unsigned t;
        set_need(k);
        @(negedge obs_clk_i);
        t = cyc + 3;
        expect_align(t, k);
        clk_present_i = 1'b1;
        wait_to(end_cyc(t, k) + 3);
        if (k <= NMAX) exit_present();
        else           exit_lane();
    endtask

    task automatic run_glitch();
        int unsigned t;
        set_need(0);
        @(negedge obs_clk_i);
        t = cyc + 3;
        clk_present_i = 1'b1;
        wait_to(t + 5);
        clk_present_i = 1'b0;
        wait_to(t + 10);
        clk_present_i = 1'b1;
        expect_align(t + 13, 0);
        wait_to(end_cyc(t + 13, 0) + 3);
        exit_present();
    endtask

    task automatic run_reset_mid_settle();
        int unsigned t;
        int unsigned r;
        set_need(99);
        @(negedge obs_clk_i);
        t = cyc + 3;
        push(t + 20, 4'b0000);
        push(t + 24, 4'b0100);
        push(t + 25, 4'b0000);
        push(t + 26, 4'b1000);
        clk_present_i = 1'b1;
        wait_to(t + 25);
        @(posedge obs_clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst_async_out", int'(obs), int'(4'b1000));
        chk("rst_async_state", int'(state_o), 0);
        set_need(2);
        repeat (3) @(negedge obs_clk_i);
        r = cyc;
        rst_i = 1'b0;
        expect_align(r + 3, 2);
        wait_to(end_cyc(r + 3, 2) + 3);
        exit_present();
    endtask

    initial begin
        rst_i         = 1'b1;
        clk_present_i = 1'b0;
        lane_en_i     = 1'b0;
        repeat (3) @(negedge obs_clk_i);
        chk("reset_out", int'(obs), int'(4'b1000));
        chk("reset_state", int'(state_o), 0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(negedge obs_clk_i);
        lane_en_i = 1'b1;
        run_align(0);
        run_align(3);
        run_align(9);
        run_glitch();
        repeat (4) run_align(int'($urandom_range(0, 9)));
        run_reset_mid_settle();
        repeat (8) @(negedge obs_clk_i);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_chk = n_chk + 1;
            $display("FAIL missing_event: got none, required cyc %0d %b",
                     e.cyc, e.v);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dphy_rx_align_ctrl.md
DPHY_RX_ALIGN_CTRL -- requirements
Module: dphy_rx_align_ctrl

Interface
REQ-001 SHALL have parameter STABLE_TICKS, default 16: consecutive obs_clk_i cycles of synchronized clk_present before the SERDES is released.
REQ-002 SHALL have parameter SERDES_RST_TICKS, default 4: obs_clk_i cycles serdes_rst_o is held after stability is reached.
REQ-003 SHALL have parameter SLIP_GAP, default 3: settle cycles after each bitslip pulse before data_i is compared.
REQ-004 SHALL have parameter MAX_SLIPS, default 8: bitslip pulses allowed before alignment failure.
REQ-005 SHALL have parameter SYNC_WORD, 8 bits, default 8'hB8: D-PHY HS sync byte.
REQ-006 SHALL have port obs_clk_i, input, 1, observed D-PHY byte clock; the only clock of the block.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port clk_present_i, input, 1, clock-detector output, asynchronous to obs_clk_i.
REQ-009 SHALL have port lane_en_i, input, 1, software lane enable, quasi-static.
REQ-010 SHALL have port data_i, input, 8, deserialized byte from the ISERDES.
REQ-011 SHALL have port serdes_rst_o, output, 1, ISERDES reset.
REQ-012 SHALL have port bitslip_o, output, 1, single-cycle bitslip pulse.
REQ-013 SHALL have port locked_o, output, 1, byte alignment achieved.
REQ-014 SHALL have port align_err_o, output, 1, alignment failed after MAX_SLIPS.
REQ-015 SHALL have port state_o, output, 3, current FSM state encoding, for debug.

Function
REQ-016 SHALL synchronize clk_present_i through 2 flops; "present" below means the synchronized value.
REQ-017 SHALL implement the states IDLE, STABLE, SRST, SETTLE, CHECK, LOCKED and FAIL.
REQ-018 IDLE: serdes_rst_o=1; SHALL go to STABLE when lane_en_i=1 and present=1.
REQ-019 STABLE: serdes_rst_o=1; the counter SHALL increment on every present cycle; on reaching STABLE_TICKS-1 the FSM SHALL go to SRST.
REQ-020 SRST: serdes_rst_o=1 for exactly SERDES_RST_TICKS cycles, then the FSM SHALL go to SETTLE with the slip count cleared.
REQ-021 SETTLE: serdes_rst_o=0; the FSM SHALL wait SLIP_GAP cycles, then go to CHECK.
REQ-022 CHECK (one cycle): if data_i==SYNC_WORD the FSM SHALL go to LOCKED.
REQ-023 CHECK on mismatch with slip count < MAX_SLIPS: bitslip_o=1 for that single cycle, slip count +1, next state SETTLE.
REQ-024 CHECK on mismatch with slip count == MAX_SLIPS: the FSM SHALL go to FAIL with no pulse.
REQ-025 LOCKED: locked_o=1 and the FSM SHALL hold regardless of data_i.
REQ-026 FAIL: align_err_o=1 (sticky) and serdes_rst_o=0; the FSM SHALL hold.
REQ-027 From any state except IDLE, present=0 or lane_en_i=0 SHALL force IDLE next cycle; this has priority over all other transitions, including a CHECK match on the same cycle.
REQ-028 FAIL SHALL exit only via REQ-027.
REQ-029 The counter SHALL be sized $clog2 of max(STABLE_TICKS, SERDES_RST_TICKS, SLIP_GAP)+1 and SHALL clear on every state entry.
REQ-030 The slip counter SHALL be sized $clog2(MAX_SLIPS+1) and SHALL saturate.
REQ-031 All outputs SHALL be registered, i.e. valid one cycle after the state decision.
REQ-032 bitslip_o SHALL never assert on two consecutive cycles.

Reset
REQ-033 rst_i SHALL asynchronously force state=IDLE, counters=0, sync flops=0, serdes_rst_o=1, bitslip_o=0, locked_o=0, align_err_o=0.
REQ-034 Deassertion SHALL be used synchronously, with the first transition no earlier than the second obs_clk_i edge after release.

Structure
REQ-035 Package dphy_pkg SHALL hold the state enum typedef (3 bits) and the SYNC_WORD default constant.
REQ-036 The 2-flop synchronizer SHALL be the sub-module sync_2ff with a parameterized reset value, reused by other blocks.
REQ-037 The FSM and counters SHALL live in the top module.

Verification
REQ-038 Present=1, lane_en=1, data_i=8'hB8 constant -> serdes_rst_o falls 16+4 cycles after synchronized present; locked_o rises after SLIP_GAP+1 further cycles; zero bitslip pulses.
REQ-039 data_i becomes 8'hB8 only after 3 slips -> exactly 3 bitslip_o pulses, each separated by >=4 cycles, then locked_o=1.
REQ-040 data_i never 8'hB8 -> exactly 8 pulses, then align_err_o=1 and locked_o=0; dropping lane_en_i -> IDLE, align_err_o=0.
REQ-041 clk_present_i drops while in LOCKED -> after 2 sync cycles plus 1, locked_o=0 and serdes_rst_o=1; restoring present reruns the full sequence.
REQ-042 Present glitch of 5 cycles during STABLE -> return to IDLE; serdes_rst_o never deasserts.
REQ-043 rst_i asserted mid-SETTLE -> outputs take their reset values immediately (asynchronously), with no extra bitslip pulse.
